// File: rtl/game_board_engine.sv
// game_board_engine
//   N x N, K-in-a-row, multi-player board engine. Owns the board storage,
//   the cursor, turn order and a sequential win/full checker, and serves a
//   registered read port to the graphics pipeline.
// Ports
//   clk        : system clock, rising edge
//   hrd_rst    : synchronous active-low reset
//   start_p    : pulse, start / restart a game
//   move_p     : pulse, advance cursor (wraps)
//   select_p   : pulse, place current player's mark at the cursor
//   rd_addr    : graphics read index (row*BOARD_N + col)
//   rd_player  : cell contents at rd_addr, one cycle later
//   cursor     : current cursor cell
//   cur_player : player whose turn it is
//   state      : 0 CLEAR, 1 IDLE, 2 PLAY, 3 CHECK, 4 OVER
//   busy       : high in CLEAR and CHECK
//   win/full   : game result flags
//   winner     : winning player, 0 on draw or before the end
module game_board_engine #(
    parameter  int BOARD_N     = 3,
    parameter  int WIN_LEN     = 3,
    parameter  int NUM_PLAYERS = 2,
    localparam int CELL_W      = $clog2(NUM_PLAYERS + 1),
    localparam int POS_W       = $clog2(BOARD_N * BOARD_N)
) (
    input  logic              clk,
    input  logic              hrd_rst,
    input  logic              start_p,
    input  logic              move_p,
    input  logic              select_p,
    input  logic [POS_W-1:0]  rd_addr,
    output logic [CELL_W-1:0] rd_player,
    output logic [POS_W-1:0]  cursor,
    output logic [CELL_W-1:0] cur_player,
    output logic [2:0]        state,
    output logic              busy,
    output logic              win,
    output logic              full,
    output logic [CELL_W-1:0] winner
);
    localparam int NCELL  = BOARD_N * BOARD_N;
    // One spare bit so that stepping off either edge shows up as >= BOARD_N.
    localparam int RC_W   = $clog2(BOARD_N) + 1;
    localparam int ST_W   = $clog2(WIN_LEN);
    localparam int CNT_W  = $clog2(WIN_LEN + 1);
    localparam int FILL_W = $clog2(NCELL + 1);
    localparam logic [POS_W-1:0] LAST = POS_W'(NCELL - 1);
    localparam logic [RC_W-1:0]  N_RC = RC_W'(BOARD_N);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_PLAY  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t              r_state, w_nxt;
    logic [CELL_W-1:0]   r_board [NCELL];
    logic [POS_W-1:0]    r_clr, r_cursor;
    logic [CELL_W-1:0]   r_cur_pl, r_winner, r_rd;
    logic                r_win, r_full, r_busy;
    logic [FILL_W-1:0]   r_fill;
    // Checker walk: direction 0..3, side 0 = negative / 1 = positive.
    logic [1:0]          r_dir;
    logic                r_side;
    logic [ST_W-1:0]     r_step;
    logic [CNT_W-1:0]    r_cnt;
    logic [RC_W-1:0]     r_r, r_c, r_ar, r_ac;

    logic [RC_W-1:0]     w_nr, w_nc;
    logic [POS_W-1:0]    w_idx, w_waddr;
    logic [CELL_W-1:0]   w_wdata;
    logic [CNT_W-1:0]    w_cnt1;
    logic                w_inb, w_hit, w_side_end, w_cur_empty;
    logic                w_we, w_place, w_win, w_exh;

    // Next probe cell along the current direction and side.
    always_comb begin
        w_nr = r_r;
        w_nc = r_c;
        if (r_dir != 2'd0) w_nr = r_side ? r_r + RC_W'(1) : r_r - RC_W'(1);
        // Anti-diagonal walks the column opposite to the row.
        if (r_dir != 2'd1) w_nc = (r_side ^ (r_dir == 2'd3)) ? r_c + RC_W'(1) : r_c - RC_W'(1);
    end

    assign w_inb       = (w_nr < N_RC) && (w_nc < N_RC);
    assign w_idx       = POS_W'(w_nr) * POS_W'(BOARD_N) + POS_W'(w_nc);
    assign w_hit       = w_inb && (r_board[w_idx] == r_cur_pl);
    assign w_cnt1      = r_cnt + CNT_W'(1);
    assign w_side_end  = !w_hit || (r_step == ST_W'(WIN_LEN - 2));
    assign w_cur_empty = (r_board[r_cursor] == '0);

    always_ff @(posedge clk) begin
        if (!hrd_rst) r_state <= S_CLEAR;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt   = r_state;
        w_we    = 1'b0;
        w_waddr = r_clr;
        w_wdata = '0;
        w_place = 1'b0;
        w_win   = 1'b0;
        w_exh   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
                if (r_clr == LAST) w_nxt = S_IDLE;
            end
            S_IDLE: if (start_p) w_nxt = S_PLAY;
            S_PLAY: begin
                if (start_p) w_nxt = S_CLEAR;
                else if (select_p && w_cur_empty) begin
                    w_place = 1'b1;
                    w_we    = 1'b1;
                    w_waddr = r_cursor;
                    w_wdata = r_cur_pl;
                    w_nxt   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_hit && (w_cnt1 >= CNT_W'(WIN_LEN))) begin
                    w_win = 1'b1;
                    w_nxt = S_OVER;
                end else if (w_side_end && r_side && (r_dir == 2'd3)) begin
                    w_exh = 1'b1;
                    w_nxt = (r_fill == FILL_W'(NCELL)) ? S_OVER : S_PLAY;
                end
            end
            S_OVER:  if (start_p) w_nxt = S_CLEAR;
            default: w_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hrd_rst && w_we) r_board[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (!hrd_rst) begin
            r_cursor <= '0;
            r_cur_pl <= CELL_W'(1);
            r_win    <= 1'b0;
            r_full   <= 1'b0;
            r_winner <= '0;
            r_busy   <= 1'b1;
            r_fill   <= '0;
            r_clr    <= '0;
            r_rd     <= '0;
            r_dir    <= '0;
            r_side   <= 1'b0;
            r_step   <= '0;
            r_cnt    <= CNT_W'(1);
            r_r      <= '0;
            r_c      <= '0;
            r_ar     <= '0;
            r_ac     <= '0;
        end else begin
            r_busy <= (w_nxt == S_CLEAR) || (w_nxt == S_CHECK);
            r_rd   <= (rd_addr <= LAST) ? r_board[rd_addr] : '0;
            case (r_state)
                S_CLEAR: begin
                    r_clr <= (r_clr == LAST) ? '0 : r_clr + POS_W'(1);
                    if (r_clr == LAST) begin
                        r_cursor <= '0;
                        r_cur_pl <= CELL_W'(1);
                        r_win    <= 1'b0;
                        r_full   <= 1'b0;
                        r_winner <= '0;
                        r_fill   <= '0;
                    end
                end
                S_PLAY: begin
                    if (w_place) begin
                        r_fill <= r_fill + FILL_W'(1);
                        r_ar   <= RC_W'(r_cursor / POS_W'(BOARD_N));
                        r_ac   <= RC_W'(r_cursor % POS_W'(BOARD_N));
                        r_r    <= RC_W'(r_cursor / POS_W'(BOARD_N));
                        r_c    <= RC_W'(r_cursor % POS_W'(BOARD_N));
                        r_dir  <= '0;
                        r_side <= 1'b0;
                        r_step <= '0;
                        r_cnt  <= CNT_W'(1);
                    end else if (!start_p && move_p && !select_p) begin
                        r_cursor <= (r_cursor == LAST) ? '0 : r_cursor + POS_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_win) begin
                        r_win    <= 1'b1;
                        r_winner <= r_cur_pl;
                        r_full   <= (r_fill == FILL_W'(NCELL));
                    end else if (w_exh) begin
                        if (r_fill == FILL_W'(NCELL)) r_full <= 1'b1;
                        else r_cur_pl <= (r_cur_pl == CELL_W'(NUM_PLAYERS)) ? CELL_W'(1)
                                                                           : r_cur_pl + CELL_W'(1);
                    end else if (w_side_end) begin
                        // Side finished: restart from the anchor on the other
                        // side, or move on to the next direction with count 1.
                        r_step <= '0;
                        r_r    <= r_ar;
                        r_c    <= r_ac;
                        if (!r_side) begin
                            r_side <= 1'b1;
                            if (w_hit) r_cnt <= w_cnt1;
                        end else begin
                            r_side <= 1'b0;
                            r_dir  <= r_dir + 2'd1;
                            r_cnt  <= CNT_W'(1);
                        end
                    end else begin
                        r_r    <= w_nr;
                        r_c    <= w_nc;
                        r_step <= r_step + ST_W'(1);
                        r_cnt  <= w_cnt1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_player  = r_rd;
    assign cursor     = r_cursor;
    assign cur_player = r_cur_pl;
    assign state      = r_state;
    assign busy       = r_busy;
    assign win        = r_win;
    assign full       = r_full;
    assign winner     = r_winner;

endmodule

// File: doc/game_board_engine.md
# game_board_engine

Parametrised N×N, K-in-a-row, multi-player board engine for the VGA game designs. It owns the board storage, cursor, turn order, and a sequential win/full checker, and exposes a synchronous read port for the graphics pipeline. It supersedes the fixed 3×3, two-player controller/memory pair and sits between the debounced button pulses and the VGA renderer.

## Interface
- BOARD_N, 3: board side length, 3..8.
- WIN_LEN, 3: line length that wins, 3..BOARD_N.
- NUM_PLAYERS, 2: players 1..NUM_PLAYERS, 2..3. Cell value 0 means empty.
- CELL_W, $clog2(NUM_PLAYERS+1): cell/player width (derived, not overridable).
- POS_W, $clog2(BOARD_N*BOARD_N): cell index width (derived). Index = row*BOARD_N + col.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- hrd_rst  in  1  reset; synchronous and active-low.
- start_p  in  1  one-cycle pulse; start or restart a game.
- move_p  in  1  one-cycle pulse; advance the cursor.
- select_p  in  1  one-cycle pulse; place the current player's mark at the cursor.
- rd_addr  in  POS_W  graphics read index.
- rd_player  out  CELL_W  cell contents at rd_addr, registered.
- cursor  out  POS_W  current cursor cell.
- cur_player  out  CELL_W  player whose turn it is.
- state  out  3  0 CLEAR, 1 IDLE, 2 PLAY, 3 CHECK, 4 OVER.
- busy  out  1  high in CLEAR and CHECK.
- win  out  1  a player completed a line.
- full  out  1  all cells are occupied.
- winner  out  CELL_W  winning player; 0 on a draw or before the game ends.

## Operation
- Reset (hrd_rst=0 at an edge): state=CLEAR, cursor=0, cur_player=1, win=0, full=0, winner=0, rd_player=0, busy=1, fill count=0, clear index=0.
- CLEAR
  - Writes 0 to one cell per cycle, index 0..N²-1, then goes to IDLE.
  - On exit: cursor=0, cur_player=1, win=0, full=0, winner=0.
  - All pulses are ignored.
- IDLE: start_p goes to PLAY. move_p and select_p are ignored.
- PLAY
  - move_p: cursor = cursor+1, wrapping from N²-1 to 0. Occupied cells are not skipped.
  - select_p on an empty cell: write cur_player, increment the fill count, latch the anchor cell, go to CHECK.
  - select_p on an occupied cell: ignored. State and cursor are unchanged.
  - Simultaneous select_p and move_p: select is serviced and move is dropped.
  - start_p: go to CLEAR (restart). start_p has priority over select_p and move_p.
- CHECK
  - Directions are evaluated in order: horizontal, vertical, diagonal (+row,+col), anti-diagonal (+row,−col).
  - For each direction, count starts at 1 (the anchor).
  - The engine steps in the negative direction, then the positive direction, at most WIN_LEN-1 steps each side.
  - One board read per cycle. A side stops on a board edge, a cell ≠ cur_player, or WIN_LEN-1 steps.
  - As soon as count ≥ WIN_LEN: win=1, winner=cur_player, go to OVER. Remaining directions are skipped.
  - If all directions are exhausted:
    - fill count = N²: full=1, winner=0, go to OVER.
    - Otherwise: cur_player = cur_player+1, wrapping NUM_PLAYERS to 1. Go to PLAY.
  - When win and full occur on the same move, win takes priority; full is also set to 1.
  - Pulses are ignored (not queued) in CHECK.
- OVER: board contents are frozen. start_p goes to CLEAR. Other pulses are ignored.
- Read port
  - Independent of state; valid in every state, including CLEAR.
  - Board arithmetic uses row/col of width $clog2(BOARD_N)+1 to detect edge crossings without wrap.
- Reset mid-operation (any state): identical to power-up reset. The board is fully cleared by CLEAR before IDLE.

## Timing
- All outputs are registered. Pulses sampled at edge t take effect at outputs after edge t.
- Cursor update: visible in the cycle after move_p.
- Board write: occurs at the edge that samples select_p. rd_addr presented in the next cycle returns the new value one cycle later (2-cycle write-to-read).
- rd_player latency: 1 cycle from rd_addr.
- CLEAR duration: exactly BOARD_N² cycles.
- CHECK duration: 1 to 8·(WIN_LEN-1) cycles. The state leaves CHECK at most 8·(WIN_LEN-1)+1 cycles after the select edge.
- win, full and winner update in the same cycle that state becomes OVER.
- busy is high for the entire CLEAR/CHECK residence, including the exit cycle's preceding edge.

## Test plan
- Reset then wait: N=3. Expect state=CLEAR for 9 cycles, then IDLE. All 9 rd_player reads = 0; cursor=0; cur_player=1.
- Cursor wrap: N=3, PLAY, 10 move_p pulses. Expect cursor 1..8, 0, 1.
- Horizontal win: N=3, K=3, P=2. P1 at 0, P2 at 3, P1 at 1, P2 at 4, P1 at 2. Expect win=1, winner=1, state=OVER within 17 cycles of the last select. Later pulses other than start_p are ignored.
- Draw: N=3 sequence 0,1,2,4,3,5,7,6,8. Expect full=1, win=0, winner=0. cur_player rotates 1,2,1,… between moves.
- Occupied and simultaneous inputs: select on an occupied cell leaves board, cursor and cur_player unchanged. select_p with move_p places the mark and cursor does not move.
- Generalised: N=4, K=3, P=3, anti-diagonal 2,5,8 for P1. Expect win with winner=1. cur_player sequence 1→2→3→1 observed. Reset asserted during CHECK gives CLEAR for 16 cycles, then IDLE with an empty board.
